register_file_param: RTL and testbench

Parametrised clocked register file: one write port, two independent registered read ports, and a hardware bulk-clear sequencer. It is the next generation of the team's 8-bit ALU operand store: it drops the shared bidirectional data bus in favour of separate read and write data paths, and it scales in width and depth. Both ALU operands are fetched in the same cycle through ports A and B.

---
 rtl/register_file_param.sv | 167 ++++++++++++++++
 tb/tb_register_file_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// ---------------------------------------------------------------------------
// register_file_param
//
// Parametrised operand store for the ALU: DEPTH entries of WIDTH bits, one
// write port, two independent registered read ports (A and B) and a hardware
// sequencer that zeroes every entry, one per cycle, on request.
//
// Parameters:
//   WIDTH   data width of every entry
//   DEPTH   number of entries (>= 2, need not be a power of two)
//   ADDR_W  address width, 2**ADDR_W >= DEPTH
//
// Ports:
//   Clk               rising-edge clock
//   Reset_n           asynchronous active-low reset
//   Write_Enable      write request
//   Write_Address     write target
//   Write_Data        write value
//   Read_Enable_A/B   read request for port A/B
//   Read_Address_A/B  read address for port A/B
//   Read_Data_A/B     registered read data for port A/B
//   Read_Valid_A/B    high for the one cycle after an accepted read
//   Clear_Start       starts a bulk clear of all entries
//   Busy              bulk clear in progress
//
// Build option:
//   RF_BYPASS_EN  when defined, a read sampled on the same edge as an
//                 accepted write to the same address returns the new data
//                 (write-first). When undefined the old contents are
//                 returned (read-first).
// ---------------------------------------------------------------------------
module register_file_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Write_Enable,
    input  logic [ADDR_W-1:0] Write_Address,
    input  logic [WIDTH-1:0]  Write_Data,
    input  logic              Read_Enable_A,
    input  logic [ADDR_W-1:0] Read_Address_A,
    output logic [WIDTH-1:0]  Read_Data_A,
    output logic              Read_Valid_A,
    input  logic              Read_Enable_B,
    input  logic [ADDR_W-1:0] Read_Address_B,
    output logic [WIDTH-1:0]  Read_Data_B,
    output logic              Read_Valid_B,
    input  logic              Clear_Start,
    output logic              Busy
);

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

    clear_state_t      state;
    logic [ADDR_W-1:0] clear_idx;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              write_ok;
    logic [WIDTH-1:0]  next_data_a;
    logic [WIDTH-1:0]  next_data_b;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    // Writes are only taken while the sequencer is idle and the target exists.
    assign write_ok = Write_Enable && !Busy && in_range(Write_Address);

    // Out-of-range reads return zero; the optional bypass forwards an
    // accepted write to a read of the same address on the same edge.
    always_comb begin
        next_data_a = '0;
        if (in_range(Read_Address_A)) begin
            next_data_a = mem[Read_Address_A];
        end
`ifdef RF_BYPASS_EN
        if (write_ok && (Write_Address == Read_Address_A)) begin
            next_data_a = Write_Data;
        end
`endif
    end

    always_comb begin
        next_data_b = '0;
        if (in_range(Read_Address_B)) begin
            next_data_b = mem[Read_Address_B];
        end
`ifdef RF_BYPASS_EN
        if (write_ok && (Write_Address == Read_Address_B)) begin
            next_data_b = Write_Data;
        end
`endif
    end

    // Storage plus clear sequencer. A write accepted on the edge that starts
    // a clear still lands; it is wiped later when the index reaches it. While
    // clearing, one entry is zeroed per edge and Busy drops on the edge that
    // zeroes the last entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state     <= IDLE;
            clear_idx <= '0;
            Busy      <= 1'b0;
        end else begin
            if (write_ok) begin
                mem[Write_Address] <= Write_Data;
            end
            case (state)
                IDLE: begin
                    if (Clear_Start) begin
                        state     <= CLEAR;
                        clear_idx <= '0;
                        Busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clear_idx] <= '0;
                    if (clear_idx == LAST_IDX) begin
                        state     <= IDLE;
                        clear_idx <= '0;
                        Busy      <= 1'b0;
                    end else begin
                        clear_idx <= clear_idx + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    clear_idx <= '0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

    // Registered read ports: data holds between reads, valid pulses once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Read_Data_A  <= '0;
            Read_Valid_A <= 1'b0;
            Read_Data_B  <= '0;
            Read_Valid_B <= 1'b0;
        end else begin
            Read_Valid_A <= Read_Enable_A;
            Read_Valid_B <= Read_Enable_B;
            if (Read_Enable_A) begin
                Read_Data_A <= next_data_a;
            end
            if (Read_Enable_B) begin
                Read_Data_B <= next_data_b;
            end
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// ---------------------------------------------------------------------------
// tb_register_file_param
//
// Drives two register files from one shared stimulus stream: a DEPTH=4
// instance and a DEPTH=3 instance (ADDR_W=2 for both, so address 3 is out of
// range on the smaller one). A behavioural model of each tracks contents,
// read results and how many clear cycles remain; a compare process checks
// every output of both instances on each falling edge, and directed steps
// add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_register_file_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [1:0] wa = '0;
    logic [7:0] wd = '0;
    logic       rea = 1'b0;
    logic [1:0] raa = '0;
    logic       reb = 1'b0;
    logic [1:0] rab = '0;
    logic       cs = 1'b0;

    // Index 0: DEPTH=4 instance, index 1: DEPTH=3 instance.
    logic [7:0] rd_a [2];
    logic [7:0] rd_b [2];
    logic       rv_a [2];
    logic       rv_b [2];
    logic       busy [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut4 (
        .Clk(clk), .Reset_n(rst_n),
        .Write_Enable(we), .Write_Address(wa), .Write_Data(wd),
        .Read_Enable_A(rea), .Read_Address_A(raa),
        .Read_Data_A(rd_a[0]), .Read_Valid_A(rv_a[0]),
        .Read_Enable_B(reb), .Read_Address_B(rab),
        .Read_Data_B(rd_b[0]), .Read_Valid_B(rv_b[0]),
        .Clear_Start(cs), .Busy(busy[0])
    );

    register_file_param #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) dut3 (
        .Clk(clk), .Reset_n(rst_n),
        .Write_Enable(we), .Write_Address(wa), .Write_Data(wd),
        .Read_Enable_A(rea), .Read_Address_A(raa),
        .Read_Data_A(rd_a[1]), .Read_Valid_A(rv_a[1]),
        .Read_Enable_B(reb), .Read_Address_B(rab),
        .Read_Data_B(rd_b[1]), .Read_Valid_B(rv_b[1]),
        .Clear_Start(cs), .Busy(busy[1])
    );

    // Behavioural model: contents, last read results and remaining clear cycles.
    logic [7:0] m_mem [2][4];
    logic [7:0] m_rd_a [2];
    logic [7:0] m_rd_b [2];
    logic       m_rv_a [2];
    logic       m_rv_b [2];
    int         m_left [2];
    logic       started = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int   d;
        logic wr_ok;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) m_mem[k][i] = 8'h00;
                m_rd_a[k] = 8'h00;
                m_rd_b[k] = 8'h00;
                m_rv_a[k] = 1'b0;
                m_rv_b[k] = 1'b0;
                m_left[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                d     = (k == 0) ? 4 : 3;
                wr_ok = we && (m_left[k] == 0) && (int'(wa) < d);
                m_rv_a[k] = rea;
                m_rv_b[k] = reb;
                if (rea) begin
                    m_rd_a[k] = (int'(raa) < d) ? m_mem[k][raa] : 8'h00;
`ifdef RF_BYPASS_EN
                    if (wr_ok && wa == raa) m_rd_a[k] = wd;
`endif
                end
                if (reb) begin
                    m_rd_b[k] = (int'(rab) < d) ? m_mem[k][rab] : 8'h00;
`ifdef RF_BYPASS_EN
                    if (wr_ok && wa == rab) m_rd_b[k] = wd;
`endif
                end
                if (wr_ok) m_mem[k][wa] = wd;
                if (m_left[k] > 0) begin
                    m_mem[k][d - m_left[k]] = 8'h00;
                    m_left[k] = m_left[k] - 1;
                end else if (cs) begin
                    m_left[k] = d;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n && started) begin
            for (int k = 0; k < 2; k++) begin
                check_output($sformatf("model rd_a[%0d]", k), rd_a[k], m_rd_a[k]);
                check_output($sformatf("model rd_b[%0d]", k), rd_b[k], m_rd_b[k]);
                check_output($sformatf("model rv_a[%0d]", k), 8'(rv_a[k]), 8'(m_rv_a[k]));
                check_output($sformatf("model rv_b[%0d]", k), 8'(rv_b[k]), 8'(m_rv_b[k]));
                check_output($sformatf("model busy[%0d]", k), 8'(busy[k]),
                             8'(m_left[k] > 0));
            end
        end
    end

    // Drive one edge worth of inputs, then release all request strobes.
    task automatic apply_stimulus(input logic we_i, input logic [1:0] wa_i,
                                  input logic [7:0] wd_i,
                                  input logic rea_i, input logic [1:0] raa_i,
                                  input logic reb_i, input logic [1:0] rab_i,
                                  input logic cs_i);
        we  = we_i;  wa  = wa_i;  wd = wd_i;
        rea = rea_i; raa = raa_i;
        reb = reb_i; rab = rab_i;
        cs  = cs_i;
        @(posedge clk);
        #1;
        we = 1'b0; rea = 1'b0; reb = 1'b0; cs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt4;
        int cnt3;
        logic [7:0] exp_same;

        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        started = 1'b1;
        check_output("reset rd_a", rd_a[0], 8'h00);
        check_output("reset rv_a", 8'(rv_a[0]), 8'h00);
        check_output("reset busy", 8'(busy[0]), 8'h00);

        // Every address reads zero on both ports after reset.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, i[1:0], 1'b1, 2'(3 - i), 1'b0);
            check_output("reset read rd_a", rd_a[0], 8'h00);
            check_output("reset read rd_b", rd_b[0], 8'h00);
            check_output("reset read rv_a", 8'(rv_a[0]), 8'h01);
            check_output("reset read rv_b", 8'(rv_b[0]), 8'h01);
        end
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        check_output("valid drops", 8'(rv_a[0]), 8'h00);

        // Dual-port read of two freshly written entries.
        apply_stimulus(1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 2'd2, 8'h3C, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 2'd2, 1'b0);
        check_output("dual rd_a", rd_a[0], 8'hA5);
        check_output("dual rd_b", rd_b[0], 8'h3C);
        check_output("dual rv_a", 8'(rv_a[0]), 8'h01);
        check_output("dual rv_b", 8'(rv_b[0]), 8'h01);

        // Read-during-write on the same address.
        apply_stimulus(1'b1, 2'd3, 8'h11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 2'd3, 8'h77, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
`ifdef RF_BYPASS_EN
        exp_same = 8'h77;
`else
        exp_same = 8'h11;
`endif
        check_output("rdw same cycle", rd_a[0], exp_same);
        check_output("rdw out of range d3", rd_a[1], 8'h00);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check_output("rdw reread", rd_a[0], 8'h77);

        // Fill, clear, and try a write while the clear is running.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, i[1:0], 8'hFF, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        end
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        cnt4 = 0;
        cnt3 = 0;
        for (int n = 0; n < 10; n++) begin
            if (busy[0]) cnt4++;
            if (busy[1]) cnt3++;
            if (!busy[0] && !busy[1]) break;
            if (n == 2) apply_stimulus(1'b1, 2'd0, 8'h55, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
            else        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        end
        check_output("busy cycles d4", 8'(cnt4), 8'd4);
        check_output("busy cycles d3", 8'(cnt3), 8'd3);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, i[1:0], 1'b1, i[1:0], 1'b0);
            check_output("post clear rd_a", rd_a[0], 8'h00);
            check_output("post clear rd_b d3", rd_b[1], 8'h00);
        end

        // Write and clear start on the same edge: write lands, then is wiped.
        apply_stimulus(1'b1, 2'd2, 8'h99, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        check_output("write+clear early read", rd_a[0], 8'h99);
        repeat (4) apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        check_output("write+clear wiped", rd_a[0], 8'h00);

        // Asynchronous reset in the middle of a clear and a read.
        apply_stimulus(1'b1, 2'd2, 8'h42, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 2'd3, 8'h42, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check_output("mid clear rd_a", rd_a[0], 8'h42);
        check_output("mid clear busy", 8'(busy[0]), 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async reset rd_a", rd_a[0], 8'h00);
        check_output("async reset rv_a", 8'(rv_a[0]), 8'h00);
        check_output("async reset busy", 8'(busy[0]), 8'h00);
        check_output("async reset busy d3", 8'(busy[1]), 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        check_output("idle after reset", 8'(busy[0]), 8'h00);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 2'd2, 1'b0);
        check_output("reset wiped addr3", rd_a[0], 8'h00);
        check_output("reset wiped addr2", rd_b[0], 8'h00);

        // Out-of-range address on the DEPTH=3 instance.
        apply_stimulus(1'b1, 2'd0, 8'h10, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 2'd1, 8'h20, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 2'd2, 8'h30, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 2'd3, 8'hEE, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 2'd0, 1'b0);
        check_output("d3 addr3 read", rd_a[1], 8'h00);
        check_output("d3 addr0 intact", rd_b[1], 8'h10);
        check_output("d4 addr3 read", rd_a[0], 8'hEE);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 2'd2, 1'b0);
        check_output("d3 addr1 intact", rd_a[1], 8'h20);
        check_output("d3 addr2 intact", rd_b[1], 8'h30);

        repeat (2) apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
